// File: rtl/perf_snapshot_streamer_if.sv
// Output stream bus of perf_snapshot_streamer: one 64-bit counter word per beat,
// valid/ready handshake, with word index and last-beat marker.
interface perf_snapshot_streamer_if;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/perf_snapshot_streamer.sv
// perf_snapshot_streamer: captures the eight 64-bit performance counters into
// shadow registers on a software request or periodic timer, then streams them
// out one word per beat over the out_if valid/ready bus.
// Optional feature macro: PERF_DELTA_EN -- stream per-interval deltas
// (input minus previous snapshot, mod 2^64) instead of absolute counts.
module perf_snapshot_streamer #(
  parameter logic [31:0] SAMPLE_PERIOD = 32'd0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [63:0]                     cycle_count,
  input  logic [63:0]                     instr_count,
  input  logic [63:0]                     mem_count,
  input  logic [63:0]                     bp_miss_count,
  input  logic [63:0]                     cache_miss_count,
  input  logic [63:0]                     stall_count,
  input  logic [63:0]                     flush_count,
  input  logic [63:0]                     branch_count,
  input  logic                            snap_req,
  perf_snapshot_streamer_if.master        out_if,
  output logic [7:0]                      snap_seq,
  output logic                            busy,
  output logic [15:0]                     drop_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]  r_state;
  logic [2:0]  r_idx;
  logic [7:0]  r_seq;
  logic [15:0] r_drop;
  logic [31:0] r_timer;
  logic [63:0] r_shadow [8];

  logic [63:0] w_live    [8];
  logic [63:0] w_capture [8];
  logic        w_timer_fire;
  logic        w_trig;
  logic        w_send;
  logic        w_hs;
  logic        w_hs_last;
  logic        w_accept;
  logic        w_drop;

  // Gather the live counters in output-index order
  always_comb begin
    w_live[0] = cycle_count;
    w_live[1] = instr_count;
    w_live[2] = mem_count;
    w_live[3] = bp_miss_count;
    w_live[4] = cache_miss_count;
    w_live[5] = stall_count;
    w_live[6] = flush_count;
    w_live[7] = branch_count;
  end

  assign w_timer_fire = (SAMPLE_PERIOD != 32'd0) && (r_timer == SAMPLE_PERIOD - 32'd1);
  assign w_trig       = snap_req | w_timer_fire;
  assign w_send       = (r_state == ST_SEND);
  assign w_hs         = w_send & out_if.out_ready;
  assign w_hs_last    = w_hs & (r_idx == 3'd7);
  // A trigger landing on the final handshake chains straight into a new snapshot
  assign w_accept     = w_trig & (~w_send | w_hs_last);
  assign w_drop       = w_trig & w_send & ~w_hs_last;

  // Free-running sample timer, counts 0..SAMPLE_PERIOD-1 in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (SAMPLE_PERIOD == 32'd0 || w_timer_fire) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

`ifdef PERF_DELTA_EN
  logic [63:0] r_prev [8];

  // Remember the raw counter values of the last accepted snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) r_prev[i] <= '0;
    end else if (w_accept) begin
      for (int unsigned i = 0; i < 8; i++) r_prev[i] <= w_live[i];
    end
  end

  // Delta against previous snapshot; modular subtraction handles counter wrap
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) w_capture[i] = w_live[i] - r_prev[i];
  end
`else
  // Absolute counts are captured as-is
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) w_capture[i] = w_live[i];
  end
`endif

  // Shadow registers load atomically on an accepted trigger only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) r_shadow[i] <= '0;
    end else if (w_accept) begin
      for (int unsigned i = 0; i < 8; i++) r_shadow[i] <= w_capture[i];
    end
  end

  // IDLE/SEND sequencing, beat index and snapshot sequence number
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_seq   <= '0;
    end else if (w_accept) begin
      r_state <= ST_SEND;
      r_idx   <= '0;
      r_seq   <= r_seq + 8'd1;
    end else if (w_hs) begin
      if (r_idx == 3'd7) begin
        r_state <= ST_IDLE;
        r_idx   <= '0;
      end else begin
        r_idx   <= r_idx + 3'd1;
      end
    end
  end

  // Saturating count of triggers that arrive while a stream is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (w_drop && r_drop != '1) begin
      r_drop <= r_drop + 16'd1;
    end
  end

  assign out_if.out_valid = w_send;
  assign out_if.out_data  = w_send ? r_shadow[r_idx] : '0;
  assign out_if.out_idx   = r_idx;
  assign out_if.out_last  = w_send & (r_idx == 3'd7);
  assign snap_seq         = r_seq;
  assign busy             = w_send;
  assign drop_count       = r_drop;

endmodule

// File: tb/tb_perf_snapshot_streamer.sv
// Testbench for perf_snapshot_streamer: directed scenarios plus randomized
// traffic, checked against a beat-queue reference model. A second instance
// with SAMPLE_PERIOD=20 checks the periodic auto-trigger.
module tb_perf_snapshot_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst20_n = 1'b0;
  logic [63:0] cnt [8];
  logic        snap_req = 1'b0;
  logic [7:0]  seq0, seq20;
  logic        busy0, busy20;
  logic [15:0] drop0, drop20;

  perf_snapshot_streamer_if bus0 ();
  perf_snapshot_streamer_if bus20 ();

  perf_snapshot_streamer #(.SAMPLE_PERIOD(32'd0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cycle_count(cnt[0]), .instr_count(cnt[1]), .mem_count(cnt[2]),
    .bp_miss_count(cnt[3]), .cache_miss_count(cnt[4]), .stall_count(cnt[5]),
    .flush_count(cnt[6]), .branch_count(cnt[7]),
    .snap_req(snap_req), .out_if(bus0),
    .snap_seq(seq0), .busy(busy0), .drop_count(drop0)
  );

  perf_snapshot_streamer #(.SAMPLE_PERIOD(32'd20)) dut20 (
    .clk(clk), .rst_n(rst20_n),
    .cycle_count(cnt[0]), .instr_count(cnt[1]), .mem_count(cnt[2]),
    .bp_miss_count(cnt[3]), .cache_miss_count(cnt[4]), .stall_count(cnt[5]),
    .flush_count(cnt[6]), .branch_count(cnt[7]),
    .snap_req(1'b0), .out_if(bus20),
    .snap_seq(seq20), .busy(busy20), .drop_count(drop20)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: outstanding beats of the current snapshot
  logic [63:0] m_words [8];
  logic [63:0] m_prev  [8];
  int          m_rem = 0;
  logic [7:0]  m_seq = '0;
  logic [15:0] m_drop = '0;
  int          n_hs = 0;

  // Period-instance monitor state
  logic [7:0] last_seq20 = '0;
  int         last_cyc20 = 0;
  int         seen20 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rem  = 0;
    m_seq  = '0;
    m_drop = '0;
    for (int i = 0; i < 8; i++) begin
      m_prev[i]  = '0;
      m_words[i] = '0;
    end
  endtask

  task automatic mon20();
    if (seq20 !== last_seq20) begin
      if (seen20 > 0) begin
        check("period_spacing", 64'(cyc - last_cyc20), 64'd20);
        check("period_seq", 64'(seq20), 64'(last_seq20 + 8'd1));
      end
      seen20++;
      last_seq20 = seq20;
      last_cyc20 = cyc;
    end
  endtask

  task automatic tick_raw();
    @(posedge clk);
    #1;
    mon20();
  endtask

  // Advance one cycle: update the model from the inputs seen at this edge,
  // then compare every dut0 output just after the edge.
  task automatic step();
    bit hs, accept;
    hs = (m_rem > 0) && bus0.out_ready;
    accept = 1'b0;
    if (m_rem == 0) begin
      accept = snap_req;
    end else begin
      if (snap_req) begin
        if (hs && m_rem == 1) accept = 1'b1;
        else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      if (hs) begin
        m_rem--;
        n_hs++;
      end
    end
    if (accept) begin
      for (int i = 0; i < 8; i++) begin
`ifdef PERF_DELTA_EN
        m_words[i] = cnt[i] - m_prev[i];
        m_prev[i]  = cnt[i];
`else
        m_words[i] = cnt[i];
`endif
      end
      m_rem = 8;
      m_seq = m_seq + 8'd1;
    end
    @(posedge clk);
    #1;
    mon20();
    check("out_valid", 64'(bus0.out_valid), 64'(m_rem != 0));
    check("busy", 64'(busy0), 64'(m_rem != 0));
    check("snap_seq", 64'(seq0), 64'(m_seq));
    check("drop_count", 64'(drop0), 64'(m_drop));
    if (m_rem != 0) begin
      check("out_idx", 64'(bus0.out_idx), 64'(8 - m_rem));
      check("out_data", bus0.out_data, m_words[8 - m_rem]);
      check("out_last", 64'(bus0.out_last), 64'(m_rem == 1));
    end
  endtask

  task automatic randomize_counters();
    for (int i = 0; i < 8; i++) cnt[i] = {$urandom, $urandom};
  endtask

  initial begin
    logic [7:0]  seq_before;
    logic [15:0] drop_before;
    logic [63:0] exp_d;

    for (int i = 0; i < 8; i++) cnt[i] = 64'(i) * 64'h1111;
    bus0.out_ready  = 1'b1;
    bus20.out_ready = 1'b1;
    model_reset();

    // Reset state
    tick_raw();
    tick_raw();
    tick_raw();
    check("rst_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_data", bus0.out_data, 64'd0);
    check("rst_idx", 64'(bus0.out_idx), 64'd0);
    check("rst_last", 64'(bus0.out_last), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_seq", 64'(seq0), 64'd0);
    check("rst_drop", 64'(drop0), 64'd0);
    rst_n   = 1'b1;
    rst20_n = 1'b1;

    // Basic snapshot: instr_count=0x10, pulse at cycle 5
    cnt[1] = 64'h10;
    for (int i = 0; i < 5; i++) step();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    check("first_seq", 64'(seq0), 64'd1);
    step();
    check("idx1_data", bus0.out_data, 64'h10);
    for (int i = 0; i < 7; i++) step();
    check("basic_done", 64'(bus0.out_valid), 64'd0);

    // Backpressure on beat idx 2
    randomize_counters();
    n_hs = 0;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    randomize_counters();
    step();
    step();
    check("bp_at_idx2", 64'(bus0.out_idx), 64'd2);
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_counters();
      step();
    end
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("bp_handshakes", 64'(n_hs), 64'd8);

    // Two drops mid-stream
    randomize_counters();
    drop_before = drop0;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    step();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    step();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("drop_two", 64'(drop0), 64'(drop_before + 16'd2));

    // Trigger coincident with the idx-7 handshake chains a new snapshot
    randomize_counters();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("chain_at7", 64'(bus0.out_idx), 64'd7);
    seq_before  = seq0;
    drop_before = drop0;
    randomize_counters();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    check("chain_idx0", 64'(bus0.out_idx), 64'd0);
    check("chain_seq", 64'(seq0), 64'(seq_before + 8'd1));
    check("chain_drop", 64'(drop0), 64'(drop_before));
    for (int i = 0; i < 8; i++) step();

    // Delta behaviour on cycle_count: 100 then 150
    cnt[0] = 64'd100;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    for (int i = 0; i < 8; i++) step();
    cnt[0] = 64'd150;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
`ifdef PERF_DELTA_EN
    exp_d = 64'd50;
`else
    exp_d = 64'd150;
`endif
    check("delta_idx0", bus0.out_data, exp_d);
    for (int i = 0; i < 8; i++) step();

    // Counter wrap: 0xFFFF_FFFF_FFFF_FFF0 then 0x10
    cnt[0] = 64'hFFFF_FFFF_FFFF_FFF0;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    for (int i = 0; i < 8; i++) step();
    cnt[0] = 64'h10;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
`ifdef PERF_DELTA_EN
    exp_d = 64'h20;
`else
    exp_d = 64'h10;
`endif
    check("wrap_idx0", bus0.out_data, exp_d);
    for (int i = 0; i < 8; i++) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      randomize_counters();
      snap_req       = ($urandom_range(0, 5) == 0);
      bus0.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    snap_req       = 1'b0;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Reset mid-stream at beat idx 4
    randomize_counters();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("abort_at_idx4", 64'(bus0.out_idx), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(bus0.out_valid), 64'd0);
    check("abort_seq", 64'(seq0), 64'd0);
    check("abort_idx", 64'(bus0.out_idx), 64'd0);
    check("abort_drop", 64'(drop0), 64'd0);
    model_reset();
    tick_raw();
    tick_raw();
    rst_n = 1'b1;
    step();
    randomize_counters();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    check("restart_idx", 64'(bus0.out_idx), 64'd0);
    check("restart_seq", 64'(seq0), 64'd1);
    for (int i = 0; i < 9; i++) step();

    // Periodic instance: enough periods observed, never dropped
    checks++;
    assert (seen20 >= 10) else begin
      errors++;
      $error("FAIL period_count observed=%0d expected>=10", seen20);
    end
    check("period_drop", 64'(drop20), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perf_snapshot_streamer.md
# perf_snapshot_streamer

Downstream consumer of the core performance counter bank. On a software request or a periodic timer it atomically captures all eight 64-bit event counters into shadow registers. It then streams them out one word per beat over a valid/ready interface to the trace/debug buffer. With the delta option compiled in, it streams per-interval deltas instead of absolute counts.

## Interface
- SAMPLE_PERIOD, 0, auto-trigger period in cycles (32-bit); 0 disables the timer.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- cycle_count, instr_count, mem_count, bp_miss_count, cache_miss_count, stall_count, flush_count, branch_count  in  64 each  live counter values
- snap_req  in  1  snapshot request, sampled every cycle
- out_ready  in  1  sink ready
- out_valid  out  1  beat valid
- out_data  out  64  counter word
- out_idx  out  3  word index: 0=cycle, 1=instr, 2=mem, 3=bp_miss, 4=cache_miss, 5=stall, 6=flush, 7=branch
- out_last  out  1  high on the index-7 beat
- snap_seq  out  8  sequence number of the snapshot being sent
- busy  out  1  high in SEND
- drop_count  out  16  triggers lost while busy, saturating

## Operation
- Trigger = snap_req | timer_fire.
- Timer is free-running in every state and counts 0..SAMPLE_PERIOD-1. timer_fire is a 1-cycle pulse on the cycle the count equals SAMPLE_PERIOD-1, after which the count wraps to 0.
- The FSM has two states, IDLE and SEND.
- IDLE, trigger:
  - Capture all 8 inputs into shadow regs on the same edge.
  - Set idx=0, increment snap_seq (wraps 255→0), go to SEND.
- SEND:
  - out_valid=1, out_data=shadow[idx], out_idx=idx, out_last=(idx==7).
  - On out_valid & out_ready: idx 0..6 → idx+1; idx 7 → IDLE.
- Trigger in SEND is not accepted and increments drop_count, which holds at 0xFFFF.
  - Exception: a trigger in the same cycle as the idx-7 handshake is accepted. The block recaptures, sets idx=0, increments snap_seq and stays in SEND; drop_count is unchanged.
- Coincident snap_req and timer_fire count as one trigger (one capture, or one drop).
- While out_valid=1 and out_ready=0: out_data, out_idx, out_last and snap_seq hold stable. out_valid never drops without a handshake.
- Counter inputs changing during SEND do not affect the shadow regs.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, snap_seq=0, drop_count=0.
  - Shadow and previous-snapshot regs = 0, timer=0, state=IDLE.
- Trigger sampled at edge T → out_valid high from cycle T+1.
- Capture reflects counter values present in cycle T.
- With out_ready held high, the 8 beats occupy cycles T+1..T+8. The earliest next capture is at the edge ending cycle T+8.
- snap_seq shows the new value from T+1 (first snapshot after reset streams with snap_seq=1).
- Reset asserted mid-SEND aborts the stream immediately. All outputs take reset values asynchronously and no partial beats resume.

## Configuration
- PERF_DELTA_EN defined:
  - On capture, shadow[i] = input[i] − prev[i] mod 2^64, and prev[i] = input[i].
  - The first snapshot after reset equals the absolute value. Counter wrap yields the correct modular delta.
- PERF_DELTA_EN undefined: shadow[i] = input[i]. No prev registers are instantiated.

## Test plan
- Reset, SAMPLE_PERIOD=0, instr_count=0x10, snap_req pulse at cycle 5, out_ready=1 → beats cycles 6..13, idx 0..7, idx1 data 0x10, out_last only at cycle 13, snap_seq=1.
- Backpressure: out_ready low for 3 cycles on beat idx 2 → out_data/out_idx/out_valid held, then idx 3 follows; exactly 8 handshakes total.
- snap_req pulsed twice mid-SEND → drop_count=2, stream contents unchanged. snap_req coincident with idx-7 handshake → new snapshot starts next cycle with idx 0, snap_seq incremented, drop_count unchanged.
- SAMPLE_PERIOD=20, out_ready=1 → a capture every 20 cycles; snap_seq increments by 1 per period.
- PERF_DELTA_EN: cycle_count 100 then 150 at two snapshots → idx0 data 100, then 50. prev=0xFFFF_FFFF_FFFF_FFF0 and new=0x10 → delta 0x20.
- Reset asserted at beat idx 4 → out_valid=0 and snap_seq=0 immediately. Next snap_req streams from idx 0 with snap_seq=1.
